// File: rtl/icache_axi_refill_pkg.sv
// Shared definitions for the I-cache AXI refill engine: AXI encodings, FSM states, line geometry.
package icache_axi_refill_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  localparam int LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } refill_state_t;

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return {a[31:4], 4'b0000};
  endfunction

  function automatic logic [31:0] word_base(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_axi_refill.sv
// I-cache refill: one miss -> one 4-beat AXI read -> 128-bit line; 6 cycles accept-to-resp at best.
// Stalls on ar_ready / r_valid / inst_resp_ready; accepts no new miss until the line is taken.
// ICACHE_REFILL_CRITICAL_WORD_FIRST_EN selects a WRAP burst starting at the missed word.
module icache_axi_refill
  import icache_axi_refill_pkg::*;
#(
  parameter logic [3:0] AXI_ID    = 4'h0,
  parameter logic [3:0] AXI_CACHE = 4'b0011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_req_valid,
  output logic         inst_req_ready,
  input  logic [31:0]  inst_req_pc,
  output logic         inst_resp_valid,
  input  logic         inst_resp_ready,
  output logic [127:0] inst_resp_cache_line,
  output logic         ar_valid,
  input  logic         ar_ready,
  output logic [3:0]   ar_id,
  output logic [31:0]  ar_address,
  output logic [3:0]   ar_length,
  output logic [2:0]   ar_size,
  output logic [1:0]   ar_burst,
  output logic [1:0]   ar_lock,
  output logic [3:0]   ar_cache,
  output logic [2:0]   ar_protect,
  input  logic         r_valid,
  output logic         r_ready,
  input  logic [3:0]   r_id,
  input  logic [31:0]  r_data,
  input  logic [1:0]   r_respond,
  input  logic         r_last
);

  refill_state_t state_q, state_d;
  logic [1:0]                   beat_q, beat_d;
  logic [LINE_WORDS-1:0][31:0]  line_q, line_d;
  logic [31:0]                  addr_q, addr_d;
  logic [1:0]                   first_word;

  logic req_fire, ar_fire, r_fire, beat_hit, resp_fire;

  assign req_fire  = inst_req_valid & inst_req_ready;
  assign ar_fire   = ar_valid & ar_ready;
  assign r_fire    = r_valid & r_ready;
  assign beat_hit  = r_fire & (r_id == AXI_ID);
  assign resp_fire = inst_resp_valid & inst_resp_ready;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign first_word = inst_req_pc[3:2];
  assign ar_address = word_base(addr_q);
  assign ar_burst   = BURST_WRAP;
`else
  assign first_word = 2'd0;
  assign ar_address = line_base(addr_q);
  assign ar_burst   = BURST_INCR;
`endif

  assign ar_id      = AXI_ID;
  assign ar_length  = 4'd3;
  assign ar_size    = SIZE_4B;
  assign ar_lock    = 2'b00;
  assign ar_cache   = AXI_CACHE;
  assign ar_protect = 3'b000;

  assign inst_resp_cache_line = line_q;

  // Response code is assumed OKAY; low address bits are only meaningful in some builds.
  logic unused_ok;
  assign unused_ok = ^{r_respond, addr_q[3:0]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_fire)  state_d = ADDR;
      ADDR: if (ar_fire)   state_d = DATA;
      DATA: if (beat_hit && r_last) state_d = RESP;
      RESP: if (resp_fire) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    inst_req_ready  = 1'b0;
    ar_valid        = 1'b0;
    r_ready         = 1'b0;
    inst_resp_valid = 1'b0;
    unique case (state_q)
      IDLE:    inst_req_ready  = 1'b1;
      ADDR:    ar_valid        = 1'b1;
      DATA:    r_ready         = 1'b1;
      RESP:    inst_resp_valid = 1'b1;
      default: inst_req_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= 2'd0;
      line_q <= '0;
      addr_q <= 32'd0;
    end else begin
      beat_q <= beat_d;
      line_q <= line_d;
      addr_q <= addr_d;
    end
  end

  // Words not reached before r_last keep whatever the previous refill left there.
  always_comb begin
    addr_d = addr_q;
    beat_d = beat_q;
    line_d = line_q;
    if (req_fire) begin
      addr_d = inst_req_pc;
      beat_d = first_word;
    end
    if (beat_hit) begin
      line_d[beat_q] = r_data;
      beat_d         = beat_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Bench for icache_axi_refill: scenario tasks plus a randomized sweep against a line-assembly model.
module tb_icache_axi_refill;
  import icache_axi_refill_pkg::*;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         inst_req_valid, inst_req_ready;
  logic [31:0]  inst_req_pc;
  logic         inst_resp_valid, inst_resp_ready;
  logic [127:0] inst_resp_cache_line;
  logic         ar_valid, ar_ready;
  logic [3:0]   ar_id;
  logic [31:0]  ar_address;
  logic [3:0]   ar_length;
  logic [2:0]   ar_size;
  logic [1:0]   ar_burst;
  logic [1:0]   ar_lock;
  logic [3:0]   ar_cache;
  logic [2:0]   ar_protect;
  logic         r_valid, r_ready;
  logic [3:0]   r_id;
  logic [31:0]  r_data;
  logic [1:0]   r_respond;
  logic         r_last;

  always #5 clk = ~clk;

  icache_axi_refill dut (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .inst_req_pc(inst_req_pc),
    .inst_resp_valid(inst_resp_valid), .inst_resp_ready(inst_resp_ready),
    .inst_resp_cache_line(inst_resp_cache_line),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_address(ar_address),
    .ar_length(ar_length), .ar_size(ar_size), .ar_burst(ar_burst), .ar_lock(ar_lock),
    .ar_cache(ar_cache), .ar_protect(ar_protect),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_respond(r_respond), .r_last(r_last)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t beats[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the line register survives between refills and is cleared only by reset.
  logic [127:0] model_line;

  int           obs_lat, obs_ar_cycles, ar_hold_bad, req_rdy_bad, line_unstable;
  bit           obs_timeout, obs_rdy_after, obs_rdy_at_req;
  logic [127:0] obs_line;
  logic [31:0]  obs_ar_addr;
  logic [1:0]   obs_burst;
  logic [3:0]   obs_len, obs_id;
  logic [2:0]   obs_size;
  refill_state_t obs_rst_state;
  bit           obs_rst_rready, obs_rst_resp;

  function automatic logic [127:0] model_refill(input logic [127:0] prev, input logic [31:0] pc);
    logic [127:0] res;
    int w;
    res = prev;
    w = CWF ? int'(pc[3:2]) : 0;
    foreach (beats[i]) begin
      if (beats[i].id == 4'h0) begin
        res[w*32 +: 32] = beats[i].data;
        w = (w + 1) % 4;
        if (beats[i].last) break;
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] model_ar_addr(input logic [31:0] pc);
    return CWF ? (pc & 32'hFFFF_FFFC) : (pc & 32'hFFFF_FFF0);
  endfunction

  task automatic load_beats(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3, input int nb);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    beats.delete();
    for (int i = 0; i < nb; i++) beats.push_back('{id: 4'h0, data: d[i], last: (i == nb - 1)});
  endtask

  // Drives one refill at negedges and records what it saw; scenario tasks do the judging.
  task automatic run_refill(input logic [31:0] pc, input int ar_stall, input bit gaps,
                            input int resp_stall, input bit hold_req, input int rst_after);
    int ar_cnt, resp_cnt, bidx;
    bit ar_done, ar_hs, r_hs, resp_hs, gap_phase;
    logic [44:0] ar_snap;
    ar_cnt = 0; resp_cnt = 0; bidx = 0;
    ar_done = 0; ar_hs = 0; r_hs = 0; resp_hs = 0; gap_phase = 0;
    ar_snap = '0;
    obs_lat = -1; obs_ar_cycles = 0; ar_hold_bad = 0; req_rdy_bad = 0; line_unstable = 0;
    obs_timeout = 1; obs_rdy_after = 0;
    @(negedge clk);
    obs_rdy_at_req = inst_req_ready;
    inst_req_valid = 1'b1;
    inst_req_pc = pc;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (resp_hs) begin
        obs_rdy_after = inst_req_ready;
        inst_req_valid = 1'b0;
        inst_resp_ready = 1'b0;
        obs_timeout = 0;
        return;
      end
      if (r_hs) bidx++;
      if (ar_hs) ar_done = 1;
      ar_hs = 0; r_hs = 0;
      if (!hold_req) inst_req_valid = 1'b0;
      if (inst_req_ready) req_rdy_bad++;
      if (rst_after >= 0 && bidx == rst_after) begin
        rst = 1'b1; r_valid = 1'b0; ar_ready = 1'b0; inst_req_valid = 1'b0;
        @(negedge clk);
        obs_rst_state  = dut.state_q;
        obs_rst_rready = r_ready;
        obs_rst_resp   = inst_resp_valid;
        rst = 1'b0;
        obs_timeout = 0;
        return;
      end
      if (ar_valid) begin
        ar_cnt++;
        if (ar_cnt == 1) begin
          ar_snap = {ar_id, ar_address, ar_length, ar_size, ar_burst};
          obs_ar_addr = ar_address; obs_burst = ar_burst; obs_len = ar_length;
          obs_size = ar_size; obs_id = ar_id;
        end else if ({ar_id, ar_address, ar_length, ar_size, ar_burst} !== ar_snap) begin
          ar_hold_bad++;
        end
        ar_ready = (ar_cnt > ar_stall);
        ar_hs = ar_ready;
      end else begin
        ar_ready = 1'($urandom_range(0, 1));
      end
      obs_ar_cycles = ar_cnt;
      r_respond = 2'($urandom);
      if (ar_done && bidx < beats.size()) begin
        gap_phase = gaps ? ~gap_phase : 1'b1;
        r_valid = gap_phase;
        r_id = beats[bidx].id;
        r_data = beats[bidx].data;
        r_last = beats[bidx].last;
        r_hs = r_valid && r_ready;
      end else begin
        r_valid = 1'b0;
      end
      if (inst_resp_valid) begin
        resp_cnt++;
        if (resp_cnt == 1) begin
          obs_lat = cyc;
          obs_line = inst_resp_cache_line;
        end else if (inst_resp_cache_line !== obs_line) begin
          line_unstable++;
        end
        inst_resp_ready = (resp_cnt > resp_stall);
        resp_hs = inst_resp_ready;
      end
    end
    $display("FAIL timeout: refill of pc %h did not complete in 400 cycles", pc);
    n_checks++; n_errors++;
    inst_req_valid = 1'b0; r_valid = 1'b0; inst_resp_ready = 1'b0; ar_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_req_valid = 0; inst_req_pc = 32'hDEAD_BEEF; inst_resp_ready = 0; ar_ready = 0;
    r_valid = 0; r_id = 0; r_data = 0; r_respond = 0; r_last = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_line = '0;
    n_checks++; if (inst_req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b want 1", inst_req_ready); end
    n_checks++; if (ar_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ar_valid: got %b want 0", ar_valid); end
    n_checks++; if (r_ready !== 1'b0) begin n_errors++; $display("FAIL reset_r_ready: got %b want 0", r_ready); end
    n_checks++; if (inst_resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid: got %b want 0", inst_resp_valid); end
    n_checks++; if (inst_resp_cache_line !== 128'd0) begin n_errors++; $display("FAIL reset_line: got %h want 0", inst_resp_cache_line); end
    n_checks++; if (ar_address !== 32'd0) begin n_errors++; $display("FAIL reset_ar_address: got %h want 0", ar_address); end
    n_checks++; if ({ar_lock, ar_cache, ar_protect} !== {2'b00, 4'b0011, 3'b000}) begin
      n_errors++; $display("FAIL ar_constants: got lock %b cache %b prot %b want 00 0011 000", ar_lock, ar_cache, ar_protect);
    end
  endtask

  task automatic test_basic();
    logic [31:0] pc;
    logic [127:0] exp;
    pc = 32'h1FC0_0014;
    load_beats(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 4);
    exp = model_refill(model_line, pc);
    run_refill(pc, 0, 0, 0, 0, -1);
    model_line = exp;
    n_checks++; if (obs_rdy_at_req !== 1'b1) begin n_errors++; $display("FAIL basic_idle_ready: got %b want 1", obs_rdy_at_req); end
    n_checks++; if (obs_ar_addr !== model_ar_addr(pc)) begin n_errors++; $display("FAIL basic_ar_address: got %h want %h", obs_ar_addr, model_ar_addr(pc)); end
    n_checks++; if (obs_burst !== (CWF ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL basic_ar_burst: got %b want %b", obs_burst, CWF ? 2'b10 : 2'b01); end
    n_checks++; if ({obs_len, obs_size, obs_id} !== {4'd3, 3'b010, 4'h0}) begin
      n_errors++; $display("FAIL basic_ar_fields: got len %0d size %b id %h want 3 010 0", obs_len, obs_size, obs_id);
    end
    n_checks++; if (obs_line !== exp) begin n_errors++; $display("FAIL basic_line: got %h want %h", obs_line, exp); end
`ifndef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    n_checks++; if (obs_line !== 128'h44444444_33333333_22222222_11111111) begin
      n_errors++; $display("FAIL basic_line_literal: got %h want 44444444333333332222222211111111", obs_line);
    end
    n_checks++; if (obs_ar_addr !== 32'h1FC0_0010) begin n_errors++; $display("FAIL basic_addr_literal: got %h want 1fc00010", obs_ar_addr); end
`endif
    n_checks++; if (obs_lat !== 6) begin n_errors++; $display("FAIL basic_latency: got %0d want 6", obs_lat); end
    n_checks++; if (req_rdy_bad !== 0) begin n_errors++; $display("FAIL basic_busy_ready: %0d busy cycles showed ready, want 0", req_rdy_bad); end
  endtask

  task automatic test_ar_backpressure();
    logic [31:0] pc;
    logic [127:0] exp;
    pc = $urandom;
    load_beats($urandom, $urandom, $urandom, $urandom, 4);
    exp = model_refill(model_line, pc);
    run_refill(pc, 5, 0, 0, 0, -1);
    model_line = exp;
    n_checks++; if (obs_ar_cycles !== 6) begin n_errors++; $display("FAIL arbp_valid_cycles: got %0d want 6", obs_ar_cycles); end
    n_checks++; if (ar_hold_bad !== 0) begin n_errors++; $display("FAIL arbp_fields_stable: %0d changes, want 0", ar_hold_bad); end
    n_checks++; if (req_rdy_bad !== 0) begin n_errors++; $display("FAIL arbp_req_ready: %0d cycles high, want 0", req_rdy_bad); end
    n_checks++; if (obs_line !== exp) begin n_errors++; $display("FAIL arbp_line: got %h want %h", obs_line, exp); end
    n_checks++; if (obs_lat !== 11) begin n_errors++; $display("FAIL arbp_latency: got %0d want 11", obs_lat); end
  endtask

  task automatic test_r_gaps_foreign();
    logic [31:0] pc;
    logic [127:0] basic_line;
    pc = 32'h1FC0_0014;
    load_beats(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 4);
    basic_line = model_refill(model_line, pc);
    beats.insert(2, '{id: 4'h5, data: 32'hBAD0_BAD0, last: 1'b0});
    model_line = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    run_refill(pc, 0, 1, 0, 0, -1);
    model_line = basic_line;
    n_checks++; if (obs_line !== basic_line) begin n_errors++; $display("FAIL gaps_foreign_line: got %h want %h", obs_line, basic_line); end
    n_checks++; if (obs_timeout !== 1'b0) begin n_errors++; $display("FAIL gaps_foreign_done: refill did not finish"); end
  endtask

  task automatic test_resp_backpressure();
    logic [31:0] pc;
    logic [127:0] exp;
    pc = $urandom;
    load_beats($urandom, $urandom, $urandom, $urandom, 4);
    exp = model_refill(model_line, pc);
    run_refill(pc, 0, 0, 3, 1, -1);
    model_line = exp;
    n_checks++; if (line_unstable !== 0) begin n_errors++; $display("FAIL respbp_line_stable: %0d changes, want 0", line_unstable); end
    n_checks++; if (req_rdy_bad !== 0) begin n_errors++; $display("FAIL respbp_req_ready: %0d cycles high before handshake, want 0", req_rdy_bad); end
    n_checks++; if (obs_rdy_after !== 1'b1) begin n_errors++; $display("FAIL respbp_ready_after: got %b want 1", obs_rdy_after); end
    n_checks++; if (obs_line !== exp) begin n_errors++; $display("FAIL respbp_line: got %h want %h", obs_line, exp); end
  endtask

  task automatic test_reset_in_data();
    logic [31:0] pc;
    logic [127:0] exp;
    pc = $urandom;
    load_beats($urandom, $urandom, $urandom, $urandom, 4);
    run_refill(pc, 0, 0, 0, 0, 2);
    model_line = '0;
    n_checks++; if (obs_rst_state !== IDLE) begin n_errors++; $display("FAIL rst_data_state: got %0d want IDLE", obs_rst_state); end
    n_checks++; if (obs_rst_rready !== 1'b0) begin n_errors++; $display("FAIL rst_data_r_ready: got %b want 0", obs_rst_rready); end
    n_checks++; if (obs_rst_resp !== 1'b0) begin n_errors++; $display("FAIL rst_data_resp_valid: got %b want 0", obs_rst_resp); end
    pc = $urandom;
    load_beats($urandom, $urandom, $urandom, $urandom, 4);
    exp = model_refill(model_line, pc);
    run_refill(pc, 1, 0, 0, 0, -1);
    model_line = exp;
    n_checks++; if (obs_line !== exp) begin n_errors++; $display("FAIL rst_data_refill_line: got %h want %h", obs_line, exp); end
  endtask

  task automatic test_early_last();
    logic [31:0] pc;
    logic [127:0] exp;
    pc = $urandom;
    load_beats(32'hA5A5_0001, 32'hA5A5_0002, 32'h0, 32'h0, 2);
    exp = model_refill(model_line, pc);
    run_refill(pc, 0, 0, 0, 0, -1);
    model_line = exp;
    n_checks++; if (obs_line !== exp) begin n_errors++; $display("FAIL early_last_line: got %h want %h", obs_line, exp); end
    n_checks++; if (obs_lat !== 4) begin n_errors++; $display("FAIL early_last_latency: got %0d want 4", obs_lat); end
  endtask

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  task automatic test_cwf();
    logic [31:0] a, b, c, d;
    a = 32'hAAAA_0000; b = 32'hBBBB_1111; c = 32'hCCCC_2222; d = 32'hDDDD_3333;
    load_beats(a, b, c, d, 4);
    run_refill(32'h0000_1008, 0, 0, 0, 0, -1);
    model_line = {b, a, d, c};
    n_checks++; if (obs_ar_addr !== 32'h0000_1008) begin n_errors++; $display("FAIL cwf_ar_address: got %h want 00001008", obs_ar_addr); end
    n_checks++; if (obs_burst !== 2'b10) begin n_errors++; $display("FAIL cwf_ar_burst: got %b want 10", obs_burst); end
    n_checks++; if (obs_line !== {b, a, d, c}) begin n_errors++; $display("FAIL cwf_line: got %h want %h", obs_line, {b, a, d, c}); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] pc;
    logic [127:0] exp;
    for (int it = 0; it < 24; it++) begin
      pc = $urandom;
      load_beats($urandom, $urandom, $urandom, $urandom, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 2) == 0)
        beats.insert(int'($urandom_range(0, beats.size() - 1)), '{id: 4'(1 + $urandom_range(0, 14)), data: $urandom, last: 1'($urandom_range(0, 1))});
      exp = model_refill(model_line, pc);
      run_refill(pc, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
      model_line = exp;
      n_checks++; if (obs_line !== exp) begin n_errors++; $display("FAIL rand_line[%0d]: got %h want %h", it, obs_line, exp); end
      n_checks++; if (obs_ar_addr !== model_ar_addr(pc)) begin n_errors++; $display("FAIL rand_ar_address[%0d]: got %h want %h", it, obs_ar_addr, model_ar_addr(pc)); end
      n_checks++; if (req_rdy_bad !== 0 || obs_rdy_after !== 1'b1) begin
        n_errors++; $display("FAIL rand_req_ready[%0d]: busy-high %0d after %b want 0 and 1", it, req_rdy_bad, obs_rdy_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_backpressure();
    test_r_gaps_foreign();
    test_resp_backpressure();
    test_reset_in_data();
    test_early_last();
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    test_cwf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icache_axi_refill.md
Name: icache_axi_refill

Overview:
- Instruction-cache refill engine between the I-cache miss path (InstReq/InstResp) and the AXI read channels (AR/R).
- Accepts one miss address and issues one 4-beat, 32-bit AXI read burst.
- Assembles the four beats into a 128-bit cache line and returns it on the InstResp handshake.
- Handles one outstanding refill at a time; fully sequential, no data-path bypass.

Parameters:
- AXI_ID, 4'h0, value driven on arid; R beats with any other rid are ignored.
- AXI_CACHE, 4'b0011, constant driven on arcache.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- inst_req_valid  in  1  I-cache miss request valid
- inst_req_ready  out  1  refill engine can accept a request
- inst_req_pc  in  32  physical miss address
- inst_resp_valid  out  1  assembled line valid
- inst_resp_ready  in  1  I-cache accepts line
- inst_resp_cache_line  out  128  refilled line; word i at bits [32i+31:32i], word 0 = lowest address
- ar_valid / ar_ready  out / in  1 / 1  AXI read-address handshake
- ar_id, ar_address, ar_length, ar_size, ar_burst  out  4, 32, 4, 3, 2  AXI AR fields
- ar_lock, ar_cache, ar_protect  out  2, 4, 3  constants 2'b00, AXI_CACHE, 3'b000
- r_valid / r_ready  in / out  1 / 1  AXI read-data handshake
- r_id, r_data, r_respond, r_last  in  4, 32, 2, 1  AXI R fields

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP. Reset enters IDLE.
- Reset values:
  - ar_valid=0, r_ready=0, inst_resp_valid=0.
  - Beat counter = 0, line register = 0, latched address = 0.
  - inst_req_ready = (state==IDLE), so it reads 1 once reset deasserts.
- IDLE:
  - inst_req_ready=1.
  - On inst_req_valid&inst_req_ready: latch pc, clear beat counter, go to ADDR.
- ADDR:
  - ar_valid=1; ar_id=AXI_ID, ar_length=4'd3, ar_size=3'b010.
  - Address and burst type are per Optional Feature.
  - Hold all AR fields stable until ar_ready; on ar_valid&ar_ready go to DATA.
  - ar_valid is never dropped before ar_ready.
- DATA:
  - r_ready=1.
  - Each r_valid&r_ready beat with r_id==AXI_ID writes r_data into the line word selected by the beat counter, then increments the counter modulo 4.
  - Beats with mismatched r_id are consumed and discarded; the counter is unchanged.
  - Matching beat with r_last=1 goes to RESP regardless of the counter value; unwritten words keep their prior contents.
  - r_respond is not checked (OKAY assumed by system).
- RESP:
  - inst_resp_valid=1; inst_resp_cache_line stable until inst_resp_ready.
  - On inst_resp_valid&inst_resp_ready go to IDLE.
  - inst_req_ready returns to 1 the cycle after the handshake, not the same cycle (no request/response overlap).
- Minimum latency with ar_ready=1 and a back-to-back R stream:
  - request accept edge → ADDR 1 cycle → 4 beat cycles → inst_resp_valid on the following cycle.
  - Total: 6 cycles from accept to resp valid.
- Reset mid-operation:
  - Any state → IDLE next edge; all valids drop immediately.
  - Outstanding AXI transactions are abandoned; the system reset resets the interconnect too.
- The ar_* and r_ready outputs are registered or state-decoded only, with no combinational path from inputs.

Optional Feature:
- Macro: ICACHE_REFILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - ar_address = {pc[31:2],2'b00}, ar_burst=2'b10 (WRAP).
  - Beat counter is initialised to pc[3:2], so the first beat lands in word pc[3:2] and wraps 3→0.
- Undefined:
  - ar_address = {pc[31:4],4'b0000}, ar_burst=2'b01 (INCR).
  - Beat counter starts at 0.

Decomposition:
- Shared defs package holds:
  - AXI burst encodings: BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
  - Size encoding SIZE_4B=3'b010.
  - Refill FSM state enum (2-bit: IDLE, ADDR, DATA, RESP).
  - Line-width constant LINE_WORDS=4.
- Single module, no sub-module.
  - The line assembler (counter plus 4x32 register) is small enough to stay inline.

Test Plan:
- Basic refill (feature off):
  - Stimulus: pc=0x1FC0_0014; ar_ready=1; R beats 0x11111111, 0x22222222, 0x33333333, 0x44444444, last on the 4th.
  - Required: ar_address=0x1FC0_0010, ar_burst=INCR, ar_length=3; cache_line=0x44444444_33333333_22222222_11111111; resp valid 6 cycles after accept.
- AR backpressure:
  - Stimulus: ar_ready low for 5 cycles.
  - Required: ar_valid and all AR fields held constant for those 5 cycles; inst_req_ready stays 0.
- R gaps and foreign id:
  - Stimulus: r_valid toggled 1/0, plus one beat with r_id=4'h5 inserted mid-burst.
  - Required: foreign beat discarded; line identical to the basic case.
- Response backpressure:
  - Stimulus: inst_resp_ready low for 3 cycles while a new inst_req_valid is asserted.
  - Required: line stable; inst_req_ready=0 until 1 cycle after the resp handshake.
- Reset in DATA:
  - Stimulus: assert rst after beat 2.
  - Required: next cycle state IDLE, r_ready=0, inst_resp_valid=0; a new refill then completes correctly.
- Critical word first (feature on):
  - Stimulus: pc=0x0000_1008; beats A, B, C, D.
  - Required: ar_address=0x0000_1008, ar_burst=WRAP; cache_line={B,A,D,C} (word2=A, word3=B, word0=C, word1=D).
